// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU constants and fetch entry type
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] NOP                = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_buffer_if.sv
// rtl/ifu_fetch_buffer_if.sv - fetch buffer IM, redirect and decode-side signals
// slave  : the fetch buffer (drives im_addr, out_*, count)
// master : the environment (IM, redirect sources, decode)
interface ifu_fetch_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   im_addr;
    logic [31:0]   im_rdata;
    logic          exc_valid;
    logic          eret_valid;
    logic [31:0]   epc;
    logic          br_valid;
    logic [31:0]   br_target;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_adel;
    logic [CW-1:0] count;

    modport slave (
        output im_addr,
        input  im_rdata,
        input  exc_valid,
        input  eret_valid,
        input  epc,
        input  br_valid,
        input  br_target,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_adel,
        output count
    );

    modport master (
        input  im_addr,
        output im_rdata,
        output exc_valid,
        output eret_valid,
        output epc,
        output br_valid,
        output br_target,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_adel,
        input  count
    );

endinterface

// File: rtl/sync_fifo_flush.sv
// rtl/sync_fifo_flush.sv - WIDTH x DEPTH FIFO with synchronous flush
// Ports: clk, reset (async, active-high), flush_i (drops all entries, wins
// over push/pop), push_i/push_data_i, pop_i, head_data_o (zero while empty),
// count_o, full_o, empty_o. A pop while full frees a slot for a same-cycle push.
module sync_fifo_flush #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the natural AW-bit wrap is modulo DEPTH
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/ifu_fetch_buffer.sv
// rtl/ifu_fetch_buffer.sv - fetch PC, IM read and DEPTH-entry fetch queue to decode
// Ports: clk, reset (async, active-high), bus (slave modport): im_addr/im_rdata
// to IM, exc/eret/br redirects, out_valid/out_ready/out_pc/out_instr/out_adel
// toward decode, count occupancy.
module ifu_fetch_buffer
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int unsigned IM_BYTES   = 16384,
    parameter int          DEPTH      = 4
) (
    input  logic               clk,
    input  logic               reset,
    ifu_fetch_buffer_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + 33'(IM_BYTES);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         redir;
    logic [31:0]  redir_target;
    logic         adel;
    logic         push, pop;
    logic         fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t wr_entry, head_entry;

    assign redir = bus.exc_valid | bus.eret_valid | bus.br_valid;

    always_comb begin
        redir_target = bus.br_target;
        if (bus.exc_valid)       redir_target = EXC_VECTOR;
        else if (bus.eret_valid) redir_target = bus.epc;
    end

    // 33-bit compare keeps IM_BASE+IM_BYTES from wrapping at the top of memory
    assign adel = (fetch_pc_q[1:0] != 2'b00)
                | ({1'b0, fetch_pc_q} < IM_LO)
                | ({1'b0, fetch_pc_q} >= IM_HI);

    assign pop  = bus.out_valid & bus.out_ready & ~redir;
    assign push = ~redir & (~fifo_full | pop);

    assign wr_entry.pc    = fetch_pc_q;
    assign wr_entry.instr = adel ? NOP : bus.im_rdata;
    assign wr_entry.adel  = adel;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redir)     fetch_pc_d = redir_target;
        else if (push) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fetch_pc_q <= RESET_PC;
        else       fetch_pc_q <= fetch_pc_d;
    end

    sync_fifo_flush #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redir),
        .push_i      (push),
        .push_data_i (wr_entry),
        .pop_i       (pop),
        .head_data_o (head_entry),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bus.im_addr   = fetch_pc_q;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_pc    = head_entry.pc;
    assign bus.out_instr = head_entry.instr;
    assign bus.out_adel  = head_entry.adel;
    assign bus.count     = fifo_count;

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// tb/tb_ifu_fetch_buffer.sv - directed self-checking bench for ifu_fetch_buffer
module tb_ifu_fetch_buffer;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ifu_fetch_buffer_if #(.DEPTH(4)) bus ();

    ifu_fetch_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // IM returns the bitwise inverse of the address as a pc-tagged word
    assign bus.im_rdata = ~bus.im_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redir();
        bus.exc_valid  = 1'b0;
        bus.eret_valid = 1'b0;
        bus.br_valid   = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.out_ready  = 1'b0;
        bus.exc_valid  = 1'b0;
        bus.eret_valid = 1'b0;
        bus.epc        = 32'h0;
        bus.br_valid   = 1'b0;
        bus.br_target  = 32'h0;

        #2;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_im_addr", bus.im_addr, 32'h3000);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        #10;
        reset = 1'b0;
        bus.out_ready = 1'b1;

        // streaming, one per cycle
        step();
        check("s1_valid", 32'(bus.out_valid), 32'h1);
        check("s1_pc", bus.out_pc, 32'h3000);
        check("s1_instr", bus.out_instr, 32'hFFFF_CFFF);
        check("s1_im_addr", bus.im_addr, 32'h3004);
        check("s1_count", 32'(bus.count), 32'h1);
        step();
        check("s2_pc", bus.out_pc, 32'h3004);
        check("s2_instr", bus.out_instr, 32'hFFFF_CFFB);
        check("s2_count", 32'(bus.count), 32'h1);
        step();
        check("s3_pc", bus.out_pc, 32'h3008);
        check("s3_im_addr", bus.im_addr, 32'h300C);

        // backpressure fills the queue
        bus.out_ready = 1'b0;
        repeat (10) step();
        check("full_count", 32'(bus.count), 32'h4);
        check("full_im_addr", bus.im_addr, 32'h3018);
        check("full_pc", bus.out_pc, 32'h3008);
        check("full_instr", bus.out_instr, 32'hFFFF_CFF7);

        // pop while full lets a push in the same cycle
        bus.out_ready = 1'b1;
        step();
        check("fullpop_count", 32'(bus.count), 32'h4);
        check("fullpop_pc", bus.out_pc, 32'h300C);
        check("fullpop_im_addr", bus.im_addr, 32'h301C);

        // branch flush from a full queue
        bus.out_ready = 1'b0;
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h3100;
        step();
        clear_redir();
        check("br1_count", 32'(bus.count), 32'h0);
        check("br1_valid", 32'(bus.out_valid), 32'h0);
        check("br1_im_addr", bus.im_addr, 32'h3100);
        check("br1_out_pc", bus.out_pc, 32'h0);
        step();
        check("br1_pc", bus.out_pc, 32'h3100);
        step();
        step();
        check("br2_pre_count", 32'(bus.count), 32'h3);
        check("br2_pre_im_addr", bus.im_addr, 32'h310C);

        // branch with count=3, pop handshake in the same cycle is ignored
        bus.out_ready = 1'b1;
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h3200;
        step();
        clear_redir();
        check("br2_count", 32'(bus.count), 32'h0);
        check("br2_valid", 32'(bus.out_valid), 32'h0);
        check("br2_im_addr", bus.im_addr, 32'h3200);
        step();
        check("br2_pc", bus.out_pc, 32'h3200);
        check("br2_instr", bus.out_instr, 32'hFFFF_CDFF);
        check("br2_count1", 32'(bus.count), 32'h1);

        // priority: exception beats eret beats branch
        bus.exc_valid  = 1'b1;
        bus.eret_valid = 1'b1;
        bus.epc        = 32'h3040;
        bus.br_valid   = 1'b1;
        bus.br_target  = 32'h3100;
        step();
        clear_redir();
        check("prio_im_addr", bus.im_addr, 32'h4180);
        check("prio_count", 32'(bus.count), 32'h0);
        step();
        check("prio_pc", bus.out_pc, 32'h4180);
        check("prio_adel", 32'(bus.out_adel), 32'h0);
        check("prio_instr", bus.out_instr, 32'hFFFF_BE7F);

        // eret alone selects epc over branch
        bus.eret_valid = 1'b1;
        bus.br_valid   = 1'b1;
        step();
        clear_redir();
        check("eret_im_addr", bus.im_addr, 32'h3040);

        // misaligned target
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h3002;
        step();
        clear_redir();
        check("mis_im_addr", bus.im_addr, 32'h3002);
        step();
        check("mis_pc", bus.out_pc, 32'h3002);
        check("mis_adel", 32'(bus.out_adel), 32'h1);
        check("mis_instr", bus.out_instr, 32'h0);
        check("mis_next_im", bus.im_addr, 32'h3006);

        // below IM_BASE
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h2FFC;
        step();
        clear_redir();
        step();
        check("lo_pc", bus.out_pc, 32'h2FFC);
        check("lo_adel", 32'(bus.out_adel), 32'h1);
        check("lo_instr", bus.out_instr, 32'h0);

        // last legal word, then first word past the window
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h6FFC;
        step();
        clear_redir();
        step();
        check("top_pc", bus.out_pc, 32'h6FFC);
        check("top_adel", 32'(bus.out_adel), 32'h0);
        check("top_instr", bus.out_instr, 32'hFFFF_9003);
        check("top_im_addr", bus.im_addr, 32'h7000);
        step();
        check("hi_pc", bus.out_pc, 32'h7000);
        check("hi_adel", 32'(bus.out_adel), 32'h1);
        check("hi_instr", bus.out_instr, 32'h0);

        // 32-bit PC wrap
        bus.br_valid  = 1'b1;
        bus.br_target = 32'hFFFF_FFFC;
        step();
        clear_redir();
        step();
        check("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_adel", 32'(bus.out_adel), 32'h1);
        check("wrap_im_addr", bus.im_addr, 32'h0);

        // async reset mid-cycle with two entries queued
        bus.out_ready = 1'b0;
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h3100;
        step();
        clear_redir();
        step();
        step();
        check("ar_pre_count", 32'(bus.count), 32'h2);
        #3;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'h0);
        check("ar_count", 32'(bus.count), 32'h0);
        check("ar_im_addr", bus.im_addr, 32'h3000);
        check("ar_out_pc", bus.out_pc, 32'h0);
        #2;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("ar_post_valid", 32'(bus.out_valid), 32'h1);
        check("ar_post_pc", bus.out_pc, 32'h3000);
        check("ar_post_instr", bus.out_instr, 32'hFFFF_CFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
